cond_unit_e: RTL and testbench

COND_UNIT_E -- requirements
Module: cond_unit_e

---
 rtl/cond_unit_e.sv | 159 +++++++++++++++
 tb/tb_cond_unit_e.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit_e.sv
// Execute-stage condition unit.
// Holds the Decode-to-Execute control pipeline register. Evaluates the
// instruction condition field against the architectural {N,Z,C,V} flags.
// Gates the state-changing controls with that result, and updates each half
// of the flags when an executed instruction requests it.
module cond_unit_e (
   input  logic       clk,
   input  logic       reset,
   input  logic       EnE,
   input  logic       FlushE,
   input  logic       PCSrcD,
   input  logic       RegWriteD,
   input  logic       MemtoRegD,
   input  logic       MemWriteD,
   input  logic       BranchD,
   input  logic       ALUSrcD,
   input  logic [1:0] ALUControlD,
   input  logic [1:0] FlagWD,
   input  logic [3:0] CondD,
   input  logic [3:0] ALUFlags,
   output logic [1:0] ALUControlE,
   output logic       ALUSrcE,
   output logic       MemtoRegE,
   output logic       PCSrcE,
   output logic       RegWriteE,
   output logic       MemWriteE,
   output logic       BranchTakenE,
   output logic       CondExE,
   output logic [3:0] Flags
);

   // Condition field encodings (instruction bits 31:28).
   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   // Execute-stage pipeline registers.
   logic       PCSrcR;
   logic       RegWriteR;
   logic       MemtoRegR;
   logic       MemWriteR;
   logic       BranchR;
   logic       ALUSrcR;
   logic [1:0] ALUControlR;
   logic [1:0] FlagWR;
   cond_e      CondR;

   // Named views of the architectural flags.
   logic flag_n;
   logic flag_z;
   logic flag_c;
   logic flag_v;

   assign flag_n = Flags[3];
   assign flag_z = Flags[2];
   assign flag_c = Flags[1];
   assign flag_v = Flags[0];

   // Pipeline register: the flush bubble takes priority over the stall enable.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: all state in clocked blocks uses non-blocking (<=) so that every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         PCSrcR      <= 1'b0;
         RegWriteR   <= 1'b0;
         MemtoRegR   <= 1'b0;
         MemWriteR   <= 1'b0;
         BranchR     <= 1'b0;
         ALUSrcR     <= 1'b0;
         ALUControlR <= 2'b00;
         FlagWR      <= 2'b00;
         CondR       <= COND_EQ;
      end else if (FlushE) begin
         PCSrcR      <= 1'b0;
         RegWriteR   <= 1'b0;
         MemtoRegR   <= 1'b0;
         MemWriteR   <= 1'b0;
         BranchR     <= 1'b0;
         ALUSrcR     <= 1'b0;
         ALUControlR <= 2'b00;
         FlagWR      <= 2'b00;
         CondR       <= COND_EQ;
      end else if (EnE) begin
         PCSrcR      <= PCSrcD;
         RegWriteR   <= RegWriteD;
         MemtoRegR   <= MemtoRegD;
         MemWriteR   <= MemWriteD;
         BranchR     <= BranchD;
         ALUSrcR     <= ALUSrcD;
         ALUControlR <= ALUControlD;
         FlagWR      <= FlagWD;
         CondR       <= cond_e'(CondD);
      end
   end

   // Condition check against the registered flags only.
   always_comb begin
      // NOTE: default first so every path assigns CondExE and no latch is inferred.
      CondExE = 1'b0;
      case (CondR)
         COND_EQ: CondExE = flag_z;
         COND_NE: CondExE = ~flag_z;
         COND_CS: CondExE = flag_c;
         COND_CC: CondExE = ~flag_c;
         COND_MI: CondExE = flag_n;
         COND_PL: CondExE = ~flag_n;
         COND_VS: CondExE = flag_v;
         COND_VC: CondExE = ~flag_v;
         COND_HI: CondExE = flag_c & ~flag_z;
         COND_LS: CondExE = ~flag_c | flag_z;
         COND_GE: CondExE = (flag_n == flag_v);
         COND_LT: CondExE = (flag_n != flag_v);
         COND_GT: CondExE = ~flag_z & (flag_n == flag_v);
         COND_LE: CondExE = flag_z | (flag_n != flag_v);
         COND_AL: CondExE = 1'b1;
         COND_NV: CondExE = 1'b1;
         default: CondExE = 1'b0;
      endcase
   end

   // Flag write belongs to the instruction already in Execute. A flush only
   // replaces the incoming instruction, so it does not block this write. A
   // stall holds both halves so the stalled instruction cannot re-trigger.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Flags <= 4'b0000;
      end else if (EnE && CondExE) begin
         if (FlagWR[1]) Flags[3:2] <= ALUFlags[3:2];
         if (FlagWR[0]) Flags[1:0] <= ALUFlags[1:0];
      end
   end

   // Condition-gated controls: a failed condition squashes all side effects.
   assign PCSrcE       = PCSrcR    & CondExE;
   assign RegWriteE    = RegWriteR & CondExE;
   assign MemWriteE    = MemWriteR & CondExE;
   assign BranchTakenE = BranchR   & CondExE;

   // Datapath controls pass straight through; they have no side effects.
   assign ALUControlE = ALUControlR;
   assign ALUSrcE     = ALUSrcR;
   assign MemtoRegE   = MemtoRegR;

endmodule

// File: tb/tb_cond_unit_e.sv
// Self-checking bench for cond_unit_e: directed vector table, multi-cycle
// corner sequences, a full condition/flag sweep and randomized traffic
// against a behavioural model.
module tb_cond_unit_e;

   logic       clk = 1'b0;
   logic       reset;
   logic       EnE, FlushE;
   logic       PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD;
   logic [1:0] ALUControlD, FlagWD;
   logic [3:0] CondD, ALUFlags;
   logic [1:0] ALUControlE;
   logic       ALUSrcE, MemtoRegE, PCSrcE, RegWriteE, MemWriteE, BranchTakenE, CondExE;
   logic [3:0] Flags;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cond_unit_e dut (
      .clk(clk), .reset(reset), .EnE(EnE), .FlushE(FlushE),
      .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
      .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
      .ALUControlD(ALUControlD), .FlagWD(FlagWD), .CondD(CondD), .ALUFlags(ALUFlags),
      .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE),
      .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .BranchTakenE(BranchTakenE), .CondExE(CondExE), .Flags(Flags)
   );

   // Output bundle: {ALUControl[1:0], ALUSrc, MemtoReg, PCSrc, RegWrite,
   //                 MemWrite, BranchTaken, CondEx, Flags[3:0]}
   logic [12:0] dut_out;
   assign dut_out = {ALUControlE, ALUSrcE, MemtoRegE, PCSrcE, RegWriteE,
                     MemWriteE, BranchTakenE, CondExE, Flags};

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [5:0] ctl;    // {PCSrc, RegWrite, MemtoReg, MemWrite, Branch, ALUSrc}
      logic [1:0] alu;
      logic [1:0] flagw;
      logic [3:0] cond;
   } instr_t;

   instr_t     m_ex;
   logic [3:0] m_flags;

   // Condition codes come in pairs; the odd code is the negation of the even one.
   function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      base = 1'b1;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: return 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   function automatic logic [12:0] model_out();
      bit ce;
      ce = cond_holds(m_ex.cond, m_flags);
      return {m_ex.alu, m_ex.ctl[0], m_ex.ctl[3], m_ex.ctl[5] & ce, m_ex.ctl[4] & ce,
              m_ex.ctl[2] & ce, m_ex.ctl[1] & ce, ce, m_flags};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic en, input logic fl, input logic [5:0] ctl,
                        input logic [3:0] cond, input logic [1:0] fw,
                        input logic [1:0] alu, input logic [3:0] af);
      EnE = en; FlushE = fl;
      {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD} = ctl;
      CondD = cond; FlagWD = fw; ALUControlD = alu; ALUFlags = af;
   endtask

   // One clock edge: advance the model from pre-edge inputs, then settle at +1.
   task automatic tick();
      logic [3:0] nf;
      nf = m_flags;
      if (EnE && cond_holds(m_ex.cond, m_flags)) begin
         if (m_ex.flagw[1]) nf[3:2] = ALUFlags[3:2];
         if (m_ex.flagw[0]) nf[1:0] = ALUFlags[1:0];
      end
      @(posedge clk);
      #1;
      m_flags = nf;
      if (FlushE) m_ex = '0;
      else if (EnE) m_ex = '{ctl: {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD},
                              alu: ALUControlD, flagw: FlagWD, cond: CondD};
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 6'd0, 4'd0, 2'd0, 2'd0, 4'd0);
      reset = 1'b1;
      m_ex = '0;
      m_flags = 4'd0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        en, fl;
      logic [5:0]  ctl;
      logic [3:0]  cond;
      logic [1:0]  fw, alu;
      logic [3:0]  af;
      logic [12:0] exp;
   } vec_t;

   vec_t vecs[11];

   initial begin
      // ALUFlags in a row is the result of the instruction leaving Execute on that edge.
      vecs[0]  = '{1'b1, 1'b0, 6'b010000, 4'hE, 2'b11, 2'b00, 4'b0000, 13'b00_0_0_0_1_0_0_1_0000};
      vecs[1]  = '{1'b1, 1'b0, 6'b000100, 4'h1, 2'b11, 2'b00, 4'b0100, 13'b00_0_0_0_0_0_0_0_0100};
      vecs[2]  = '{1'b1, 1'b0, 6'b010000, 4'hE, 2'b10, 2'b10, 4'b1000, 13'b10_0_0_0_1_0_0_1_0100};
      vecs[3]  = '{1'b1, 1'b0, 6'b000000, 4'h0, 2'b00, 2'b00, 4'b1111, 13'b00_0_0_0_0_0_0_1_1100};
      vecs[4]  = '{1'b1, 1'b0, 6'b000000, 4'hE, 2'b01, 2'b00, 4'b0000, 13'b00_0_0_0_0_0_0_1_1100};
      vecs[5]  = '{1'b1, 1'b0, 6'b001001, 4'hA, 2'b00, 2'b01, 4'b0011, 13'b01_1_1_0_0_0_0_1_1111};
      vecs[6]  = '{1'b1, 1'b1, 6'b100010, 4'hE, 2'b11, 2'b11, 4'b0000, 13'b00_0_0_0_0_0_0_1_1111};
      vecs[7]  = '{1'b0, 1'b0, 6'b111111, 4'hE, 2'b11, 2'b11, 4'b0000, 13'b00_0_0_0_0_0_0_1_1111};
      vecs[8]  = '{1'b1, 1'b0, 6'b111111, 4'hD, 2'b00, 2'b11, 4'b0000, 13'b11_1_1_1_1_1_1_1_1111};
      vecs[9]  = '{1'b1, 1'b0, 6'b111111, 4'hB, 2'b00, 2'b11, 4'b0000, 13'b11_1_1_0_0_0_0_0_1111};
      vecs[10] = '{1'b0, 1'b1, 6'b111111, 4'hE, 2'b11, 2'b11, 4'b0000, 13'b00_0_0_0_0_0_0_1_1111};

      reset = 1'b0;
      drive(1'b0, 1'b0, 6'd0, 4'd0, 2'd0, 2'd0, 4'd0);
      #1;
      do_reset();
      check("reset_state", dut_out, 13'd0);

      // Table-driven directed vectors.
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].en, vecs[i].fl, vecs[i].ctl, vecs[i].cond, vecs[i].fw, vecs[i].alu, vecs[i].af);
         tick();
         check($sformatf("vec%0d", i), dut_out, vecs[i].exp);
      end

      // C,V held by a logical-op flag write, starting from cleared flags.
      do_reset();
      drive(1'b1, 1'b0, 6'b010000, 4'hE, 2'b10, 2'b00, 4'b0000);
      tick();
      drive(1'b1, 1'b0, 6'b000000, 4'hE, 2'b00, 2'b00, 4'b1111);
      tick();
      check("logical_flags", Flags, 4'b1100);

      // Branch taken, then flushed on the next edge while its flag write still lands.
      do_reset();
      drive(1'b1, 1'b0, 6'b100010, 4'hC, 2'b11, 2'b00, 4'b0000);
      tick();
      check("gt_branch_taken", {PCSrcE, BranchTakenE}, 2'b11);
      drive(1'b1, 1'b1, 6'b010000, 4'hE, 2'b00, 2'b00, 4'b0100);
      tick();
      check("flush_branch_bubble", {PCSrcE, BranchTakenE, RegWriteE}, 3'b000);
      check("flush_flag_lands", Flags, 4'b0100);

      // Three-cycle stall with a flag-writing instruction and changing ALU flags.
      do_reset();
      drive(1'b1, 1'b0, 6'b010000, 4'hE, 2'b11, 2'b00, 4'b0000);
      tick();
      for (int s = 0; s < 3; s++) begin
         drive(1'b0, 1'b0, 6'b000000, 4'h0, 2'b00, 2'b00, 4'(s * 5 + 5));
         tick();
         check($sformatf("stall_hold%0d", s), {Flags, RegWriteE}, 5'b0000_1);
      end
      drive(1'b1, 1'b0, 6'b000000, 4'h0, 2'b00, 2'b00, 4'b0110);
      tick();
      check("stall_release_flags", Flags, 4'b0110);

      // Async reset pulse mid-stall clears outputs without waiting for an edge.
      drive(1'b1, 1'b0, 6'b110110, 4'hE, 2'b11, 2'b11, 4'b0000);
      tick();
      drive(1'b0, 1'b0, 6'b110110, 4'hE, 2'b11, 2'b11, 4'b1111);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_immediate", dut_out, 13'd0);
      m_ex = '0;
      m_flags = 4'd0;
      #2;
      reset = 1'b0;
      drive(1'b1, 1'b0, 6'b010000, 4'hE, 2'b11, 2'b00, 4'b0000);
      tick();
      check("after_reset_load", dut_out, 13'b00_0_0_0_1_0_0_1_0000);

      // Full sweep of the condition table over every flag value.
      for (int f = 0; f < 16; f++) begin
         drive(1'b1, 1'b0, 6'b000000, 4'hE, 2'b11, 2'b00, 4'b0000);
         tick();
         for (int c = 0; c < 16; c++) begin
            drive(1'b1, 1'b0, 6'b000000, 4'(c), 2'b00, 2'b00, 4'(f));
            tick();
            check($sformatf("cond_c%0d_f%0d", c, f), CondExE, cond_holds(4'(c), 4'(f)));
         end
      end

      // Randomized traffic against the model.
      do_reset();
      for (int r = 0; r < 600; r++) begin
         drive(($urandom % 4) != 0, ($urandom % 8) == 0, 6'($urandom), 4'($urandom),
               2'($urandom), 2'($urandom), 4'($urandom));
         tick();
         check($sformatf("random%0d", r), dut_out, model_out());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
